imx_lane_align_ctrl: RTL and testbench

//  Per-camera deserializer lane-alignment sequencer, one instance per camera in the cam clock domain.
//  - Pulses SERDES/IDELAY resets, then sweeps the 5-bit input tap delay over 0..31 on all lanes in parallel.
//  - Per lane, finds the longest contiguous tap range that samples the training byte cleanly; programs its centre.
//  - Reports per-lane lock, busy and done to the AXI control block.

---
 rtl/imx_lane_align_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_imx_lane_align_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imx_lane_align_ctrl.sv
// imx_lane_align_ctrl
// Per-camera deserializer lane-alignment sequencer (cam clock domain).
// Pulses the SERDES/IDELAY resets, sweeps the shared 5-bit tap delay over 0..31,
// tracks the longest clean window per lane and programs that window's centre.
// Optional feature macro: IMX_LANE_ALIGN_WINDOW_EN adds o_win_len (best window length per lane).
module imx_lane_align_ctrl #(
    parameter int         LANE_WIDTH       = 8,
    parameter logic [7:0] TRAINING_PATTERN = 8'h7F,
    parameter int         RST_CYCLES       = 8,
    parameter int         SETTLE_CYCLES    = 16,
    parameter int         SAMPLE_COUNT     = 64,
    parameter int         MIN_WINDOW       = 4,
    parameter logic [4:0] DEFAULT_TAP      = 5'd0
) (
    input  logic                    i_cam_clk,
    input  logic                    i_cam_rst,
    input  logic                    i_start,
    input  logic [8*LANE_WIDTH-1:0] i_raw_data,
    output logic [5*LANE_WIDTH-1:0] o_tap_data,
    output logic                    o_serdes_io_rst,
    output logic                    o_tap_delay_rst,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [LANE_WIDTH-1:0]   o_lane_locked
`ifdef IMX_LANE_ALIGN_WINDOW_EN
    ,
    output logic [6*LANE_WIDTH-1:0] o_win_len
`endif
);

    // One counter serves all timed phases, so it is sized for the longest one.
    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES)
                           ? ((RST_CYCLES > SAMPLE_COUNT) ? RST_CYCLES : SAMPLE_COUNT)
                           : ((SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_COUNT - 1);
    localparam logic [5:0]       MIN_LEN     = 6'(MIN_WINDOW);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_SETTLE, S_SAMPLE, S_UPDATE, S_FINAL, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [4:0]                  tap_q, tap_d;
    logic [LANE_WIDTH-1:0]       pass_q, pass_d;
    logic [LANE_WIDTH-1:0][5:0]  run_len_q, run_len_d;
    logic [LANE_WIDTH-1:0][4:0]  run_start_q, run_start_d;
    logic [LANE_WIDTH-1:0][5:0]  best_len_q, best_len_d;
    logic [LANE_WIDTH-1:0][4:0]  best_start_q, best_start_d;
    logic [LANE_WIDTH-1:0][4:0]  tap_out_q, tap_out_d;
    logic [LANE_WIDTH-1:0]       locked_q, locked_d;

    logic [LANE_WIDTH-1:0][5:0]  new_len;
    logic [LANE_WIDTH-1:0][4:0]  new_start;
    logic [LANE_WIDTH-1:0][4:0]  centre;
    logic                        start_acc;

    assign start_acc = (state_q == S_IDLE) && i_start;

    // State register; a reset mid-sweep drops straight back to IDLE.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_cam_clk) begin
        if (i_cam_rst) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state sequencing through reset, per-tap settle/sample/update, and result.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (i_start) state_d = S_RESET;
            S_RESET:  if (cnt_q == RST_LAST) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = S_UPDATE;
            S_UPDATE: state_d = (tap_q == 5'd31) ? S_FINAL : S_SETTLE;
            S_FINAL:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Per-lane run extension candidates and window centre (sum never exceeds 31).
    always_comb begin
        for (int n = 0; n < LANE_WIDTH; n++) begin
            new_len[n]   = run_len_q[n] + 6'd1;
            new_start[n] = (run_len_q[n] == 6'd0) ? tap_q : run_start_q[n];
            centre[n]    = best_start_q[n] + best_len_q[n][5:1];
        end
    end

    // Datapath next-state: phase counter, tap sweep, pass flags and window trackers.
    always_comb begin
        cnt_d        = '0;
        tap_d        = tap_q;
        pass_d       = pass_q;
        run_len_d    = run_len_q;
        run_start_d  = run_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        tap_out_d    = tap_out_q;
        locked_d     = locked_q;

        if ((state_q == S_RESET || state_q == S_SETTLE || state_q == S_SAMPLE) &&
            (state_d == state_q))
            cnt_d = cnt_q + 1'b1;

        if (start_acc) begin
            tap_d        = '0;
            pass_d       = '0;
            run_len_d    = '0;
            run_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
            tap_out_d    = '0;
            locked_d     = '0;
        end

        // Every lane starts each tap as passing; any bad byte clears it for the tap.
        if (state_q == S_SETTLE && state_d == S_SAMPLE)
            pass_d = '1;

        if (state_q == S_SAMPLE) begin
            for (int n = 0; n < LANE_WIDTH; n++)
                pass_d[n] = pass_q[n] && (i_raw_data[8*n +: 8] == TRAINING_PATTERN);
        end

        // Strict '>' keeps the earliest window on equal lengths.
        if (state_q == S_UPDATE) begin
            for (int n = 0; n < LANE_WIDTH; n++) begin
                if (pass_q[n]) begin
                    run_len_d[n]   = new_len[n];
                    run_start_d[n] = new_start[n];
                    if (new_len[n] > best_len_q[n]) begin
                        best_len_d[n]   = new_len[n];
                        best_start_d[n] = new_start[n];
                    end
                end else begin
                    run_len_d[n] = '0;
                end
            end
            if (tap_q != 5'd31) tap_d = tap_q + 5'd1;
        end

        if (state_q == S_FINAL) begin
            for (int n = 0; n < LANE_WIDTH; n++) begin
                locked_d[n]  = (best_len_q[n] >= MIN_LEN);
                tap_out_d[n] = (best_len_q[n] >= MIN_LEN) ? centre[n] : DEFAULT_TAP;
            end
        end
    end

    // Datapath registers.
    // NOTE: the window trackers are ordinary flops, not a RAM, so they take the reset too.
    always_ff @(posedge i_cam_clk) begin
        if (i_cam_rst) begin
            cnt_q        <= '0;
            tap_q        <= '0;
            pass_q       <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            tap_out_q    <= '0;
            locked_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            tap_q        <= tap_d;
            pass_q       <= pass_d;
            run_len_q    <= run_len_d;
            run_start_q  <= run_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            tap_out_q    <= tap_out_d;
            locked_q     <= locked_d;
        end
    end

    // Moore outputs: sweep tap during the sweep, computed result in FINAL, held result otherwise.
    always_comb begin
        o_busy          = (state_q != S_IDLE);
        o_done          = (state_q == S_DONE);
        o_serdes_io_rst = (state_q == S_RESET);
        o_tap_delay_rst = (state_q == S_RESET);
        o_lane_locked   = locked_q;
        o_tap_data      = tap_out_q;
        if (state_q == S_RESET || state_q == S_SETTLE ||
            state_q == S_SAMPLE || state_q == S_UPDATE)
            o_tap_data = {LANE_WIDTH{tap_q}};
        else if (state_q == S_FINAL)
            o_tap_data = tap_out_d;
`ifdef IMX_LANE_ALIGN_WINDOW_EN
        o_win_len = best_len_q;
`endif
    end

endmodule

// File: tb/tb_imx_lane_align_ctrl.sv
// Testbench for imx_lane_align_ctrl: a channel model feeds training bytes that depend on
// the swept tap; expected taps/locks are queued at start and compared at o_done.
module tb_imx_lane_align_ctrl;

    localparam int         LW       = 8;
    localparam logic [7:0] PAT      = 8'h7F;
    localparam int         RST_C    = 8;
    localparam int         SETTLE_C = 16;
    localparam int         SAMPLE_C = 64;
    localparam int         MIN_W    = 4;
    localparam logic [4:0] DEF_TAP  = 5'd0;
    localparam int         TAP_CYC  = SETTLE_C + SAMPLE_C + 1;
    // Inclusive cycle count from the start cycle to the o_done cycle.
    localparam int         LATENCY  = 1 + RST_C + 32 * TAP_CYC + 2;
    // Index of the o_done cycle, counting the cycle after the start edge as 0.
    localparam int         DONE_C   = LATENCY - 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [8*LW-1:0]   raw;
    logic [5*LW-1:0]   tap_data;
    logic              serdes_rst, tap_rst, busy, done;
    logic [LW-1:0]     locked;
`ifdef IMX_LANE_ALIGN_WINDOW_EN
    logic [6*LW-1:0]   win_len;
`endif

    always #5 clk = ~clk;

    imx_lane_align_ctrl #(
        .LANE_WIDTH(LW), .TRAINING_PATTERN(PAT), .RST_CYCLES(RST_C),
        .SETTLE_CYCLES(SETTLE_C), .SAMPLE_COUNT(SAMPLE_C),
        .MIN_WINDOW(MIN_W), .DEFAULT_TAP(DEF_TAP)
    ) dut (
        .i_cam_clk(clk), .i_cam_rst(rst), .i_start(start), .i_raw_data(raw),
        .o_tap_data(tap_data), .o_serdes_io_rst(serdes_rst), .o_tap_delay_rst(tap_rst),
        .o_busy(busy), .o_done(done), .o_lane_locked(locked)
`ifdef IMX_LANE_ALIGN_WINDOW_EN
        , .o_win_len(win_len)
`endif
    );

    typedef struct {
        logic [5*LW-1:0] taps;
        logic [LW-1:0]   lock;
        logic [6*LW-1:0] win;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] pass_map [LW];
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Position of the single bad byte a failing tap shows inside its sample phase.
    function automatic int glitch_pos(int lane, int tap);
        return (tap * 7 + lane * 13 + 5) % SAMPLE_C;
    endfunction

    // Reference: longest run by scanning from every start tap; first found wins ties.
    task automatic push_expected();
        exp_t e;
        e.taps = '0; e.lock = '0; e.win = '0;
        for (int lane = 0; lane < LW; lane++) begin
            int bl = 0;
            int bs = 0;
            for (int s = 0; s < 32; s++) begin
                int len = 0;
                while (s + len < 32 && pass_map[lane][s + len]) len++;
                if (len > bl) begin bl = len; bs = s; end
            end
            e.win[6*lane +: 6] = 6'(bl);
            e.lock[lane]       = (bl >= MIN_W);
            e.taps[5*lane +: 5] = (bl >= MIN_W) ? 5'(bs + bl / 2) : DEF_TAP;
        end
        sb_q.push_back(e);
    endtask

    // Channel model for cycle c after the start edge: random outside sampling windows.
    task automatic drive_data(input int c);
        for (int lane = 0; lane < LW; lane++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (c >= RST_C) begin
                int k   = c - RST_C;
                int tap = k / TAP_CYC;
                int p   = k % TAP_CYC;
                if (tap < 32 && p >= SETTLE_C && p < SETTLE_C + SAMPLE_C) begin
                    b = PAT;
                    if (!pass_map[lane][tap] && (p - SETTLE_C) == glitch_pos(lane, tap))
                        b = 8'h3F;
                end
            end
            raw[8*lane +: 8] = b;
        end
    endtask

    task automatic run_sweep(input string name, input bit hold_start, input int abort_c);
        int     done_at = -1;
        int     dcount;
        exp_t   e;
        logic [4:0] t;
        if (abort_c < 0) push_expected();
        @(negedge clk);
        start = 1'b1;
        drive_data(-1);
        @(posedge clk);
        for (int c = 0; c <= DONE_C + 10 && done_at < 0; c++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            drive_data(c);
            if (c == abort_c) begin
                rst = 1'b1;
                @(negedge clk);
                n_cmp++;
                if ({busy, done, serdes_rst, tap_rst} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL %s abort_ctrl: got %b expected 0000", name, {busy, done, serdes_rst, tap_rst});
                end
                n_cmp++;
                if (tap_data !== '0 || locked !== '0) begin
                    n_fail++;
                    $display("FAIL %s abort_result: got taps %h lock %h expected 0", name, tap_data, locked);
                end
`ifdef IMX_LANE_ALIGN_WINDOW_EN
                n_cmp++;
                if (win_len !== '0) begin
                    n_fail++;
                    $display("FAIL %s abort_win: got %h expected 0", name, win_len);
                end
`endif
                rst = 1'b0;
                start = 1'b0;
                dcount = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (done || busy) dcount++;
                end
                n_cmp++;
                if (dcount !== 0) begin
                    n_fail++;
                    $display("FAIL %s abort_quiet: got %0d busy/done cycles expected 0", name, dcount);
                end
                return;
            end
            if (c == 0 || c == RST_C - 1) begin
                n_cmp++;
                if ({serdes_rst, tap_rst} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL %s rst_pulse c=%0d: got %b expected 11", name, c, {serdes_rst, tap_rst});
                end
            end
            if (c == RST_C) begin
                n_cmp++;
                if ({serdes_rst, tap_rst} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s rst_release: got %b expected 00", name, {serdes_rst, tap_rst});
                end
            end
            if (c >= RST_C && c < DONE_C - 1 && ((c - RST_C) % TAP_CYC) == 40) begin
                t = 5'((c - RST_C) / TAP_CYC);
                n_cmp++;
                if (tap_data !== {LW{t}} || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s sweep_tap%0d: got taps %h busy %b expected %h busy 1",
                             name, t, tap_data, busy, {LW{t}});
                end
            end
            if (done === 1'b1) done_at = c;
        end
        n_cmp++;
        if (done_at != DONE_C) begin
            n_fail++;
            $display("FAIL %s latency: got done at cycle %0d expected %0d", name, done_at, DONE_C);
        end
        if (done_at < 0) return;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got o_done expected no result pending", name);
            return;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (tap_data !== e.taps) begin
            n_fail++;
            $display("FAIL %s taps: got %h expected %h", name, tap_data, e.taps);
        end
        n_cmp++;
        if (locked !== e.lock) begin
            n_fail++;
            $display("FAIL %s locked: got %h expected %h", name, locked, e.lock);
        end
`ifdef IMX_LANE_ALIGN_WINDOW_EN
        n_cmp++;
        if (win_len !== e.win) begin
            n_fail++;
            $display("FAIL %s win_len: got %h expected %h", name, win_len, e.win);
        end
`endif
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s after_done: got busy/done %b expected 00", name, {busy, done});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tap_data !== e.taps || locked !== e.lock) begin
            n_fail++;
            $display("FAIL %s persist: got busy %b taps %h lock %h expected 0 %h %h",
                     name, busy, tap_data, locked, e.taps, e.lock);
        end
    endtask

    task automatic set_all_pass();
        for (int l = 0; l < LW; l++) pass_map[l] = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; raw = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, serdes_rst, tap_rst} !== 4'b0000 || tap_data !== '0 || locked !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctrl %b taps %h lock %h expected all 0",
                     {busy, done, serdes_rst, tap_rst}, tap_data, locked);
        end
`ifdef IMX_LANE_ALIGN_WINDOW_EN
        n_cmp++;
        if (win_len !== '0) begin
            n_fail++;
            $display("FAIL reset_win: got %h expected 0", win_len);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_all_pass();
        set_all_pass();
        run_sweep("all_pass", 1'b0, -1);
    endtask

    task automatic test_single_window();
        set_all_pass();
        pass_map[0] = 32'h0003_FC00;   // 10..17
        pass_map[5] = 32'hFC00_0000;   // 26..31, closes at sweep end
        pass_map[6] = 32'h0000_000F;   // 0..3, exactly the minimum
        pass_map[7] = 32'h0000_0000;   // never clean
        run_sweep("single_window", 1'b0, -1);
    endtask

    task automatic test_short_window();
        set_all_pass();
        pass_map[2] = 32'h0030_0038;   // 3..5 and 20..21
        run_sweep("short_window", 1'b0, -1);
    endtask

    task automatic test_tie();
        set_all_pass();
        pass_map[1] = 32'h0003_F0FC;   // 2..7 and 12..17
        run_sweep("tie", 1'b0, -1);
    endtask

    task automatic test_glitch();
        set_all_pass();
        pass_map[3] = 32'h0000_FDF0;   // 4..15 with a bad byte at tap 9
        run_sweep("glitch", 1'b0, -1);
    endtask

    task automatic test_abort_restart();
        set_all_pass();
        pass_map[4] = 32'h00FF_0000;
        run_sweep("abort", 1'b0, RST_C + 7 * TAP_CYC + 30);
        run_sweep("restart", 1'b0, -1);
    endtask

    task automatic test_start_held();
        for (int l = 0; l < LW; l++) begin
            int s = $urandom_range(0, 31);
            int n = $urandom_range(0, 32 - s);
            logic [31:0] m = '0;
            for (int b = s; b < s + n; b++) m[b] = 1'b1;
            pass_map[l] = m | (32'h1 << $urandom_range(0, 31));
        end
        run_sweep("start_held", 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_single_window();
        test_short_window();
        test_tie();
        test_glitch();
        test_abort_restart();
        test_start_held();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
